cpu_step_sequencer: RTL and testbench

//  Sequences the single-cycle semi-CPU datapath (PC, instruction memory, register file, ALU, 7-seg) as a multi-phase machine.

---
 rtl/cpu_step_sequencer_if.sv | 28 ++
 rtl/cpu_step_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cpu_step_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_sequencer_if.sv
// Datapath-facing bundle of the step sequencer: instruction/decoder/PC
// status flow into the sequencer, per-phase enables flow out.
//
// Handshake: there is no ready path. Every enable (ir_load, rf_we, pc_en,
// disp_load) is a single-cycle strobe that the datapath must act on in the
// cycle it is high. The status inputs are level signals that must be stable
// while the sequencer is busy.
interface cpu_step_sequencer_if #(
    parameter int PC_W = 5
);
    logic [31:0]     instruction;
    logic            dec_reg_write;
    logic [PC_W-1:0] pc_address;
    logic            ir_load;
    logic            rf_we;
    logic            pc_en;
    logic            disp_load;

    modport master (
        input  instruction, dec_reg_write, pc_address,
        output ir_load, rf_we, pc_en, disp_load
    );

    modport slave (
        output instruction, dec_reg_write, pc_address,
        input  ir_load, rf_we, pc_en, disp_load
    );
endinterface

// File: rtl/cpu_step_sequencer.sv
// Multi-phase sequencer for the semi-CPU datapath. A debounced step button
// (or a periodic timer in run mode) starts one FETCH/EXEC/WB instruction.
// All enables are registered Moore outputs that line up with the state.
module cpu_step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_PERIOD      = 100000000,
    parameter int PC_W            = 5,
    parameter int LAST_PC         = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  control_btn_i,
    input  logic                  run_mode_i,
    cpu_step_sequencer_if.master  dp,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic [15:0]           step_count_o,
    output logic [2:0]            state_o
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RUN_W = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_PERIOD - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(LAST_PC);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_e;

    // Button path registers
    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;
    logic            btn_pulse_q;

    // Run timer registers
    logic [RUN_W-1:0] run_cnt_q;
    logic             run_pulse_q;

    // FSM and registered outputs
    state_e      state_q, state_d;
    logic        ir_load_q, ir_load_d;
    logic        rf_we_q, rf_we_d;
    logic        pc_en_q, pc_en_d;
    logic        disp_load_q, disp_load_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic [15:0] step_count_q, step_count_d;

    logic trigger;
    logic is_halt_word;
    logic at_last_pc;

    assign trigger      = run_mode_i ? run_pulse_q : btn_pulse_q;
    assign is_halt_word = (dp.instruction == 32'h0000_0000) ||
                          (dp.instruction == 32'h0000_0073);
    assign at_last_pc   = (dp.pc_address == PC_LAST);

    // Synchronise and debounce the raw button; pulse on an accepted rising level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b0;
            btn_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= control_btn_i;
            sync2_q     <= sync1_q;
            btn_pulse_q <= 1'b0;
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_q  <= ~db_level_q;
                    db_cnt_q    <= '0;
                    btn_pulse_q <= ~db_level_q;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Free-running step timer, held at zero outside run mode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_cnt_q   <= '0;
            run_pulse_q <= 1'b0;
        end else if (!run_mode_i) begin
            run_cnt_q   <= '0;
            run_pulse_q <= 1'b0;
        end else if (run_cnt_q == RUN_LAST) begin
            run_cnt_q   <= '0;
            run_pulse_q <= 1'b1;
        end else begin
            run_cnt_q   <= run_cnt_q + 1'b1;
            run_pulse_q <= 1'b0;
        end
    end

    // Next state, and next values of the outputs that belong to that state.
    always_comb begin
        state_d      = state_q;
        ir_load_d    = 1'b0;
        rf_we_d      = 1'b0;
        pc_en_d      = 1'b0;
        disp_load_d  = 1'b0;
        busy_d       = 1'b0;
        halted_d     = 1'b0;
        step_count_d = step_count_q;

        case (state_q)
            IDLE:    if (trigger) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = is_halt_word ? HALT : WB;
            WB:      state_d = at_last_pc ? HALT : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // WB strobes are decided on entry so they are high exactly in WB;
        // the PC is stable through the whole instruction.
        if (state_q == EXEC && state_d == WB) begin
            rf_we_d     = dp.dec_reg_write;
            disp_load_d = 1'b1;
            pc_en_d     = !at_last_pc;
        end

        if (state_q == WB && step_count_q != 16'hFFFF) begin
            step_count_d = step_count_q + 16'd1;
        end

        ir_load_d = (state_d == FETCH);
        busy_d    = (state_d == FETCH) || (state_d == EXEC) || (state_d == WB);
        halted_d  = (state_d == HALT);
    end

    // State register and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ir_load_q    <= 1'b0;
            rf_we_q      <= 1'b0;
            pc_en_q      <= 1'b0;
            disp_load_q  <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            ir_load_q    <= ir_load_d;
            rf_we_q      <= rf_we_d;
            pc_en_q      <= pc_en_d;
            disp_load_q  <= disp_load_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
        end
    end

    assign dp.ir_load   = ir_load_q;
    assign dp.rf_we     = rf_we_q;
    assign dp.pc_en     = pc_en_q;
    assign dp.disp_load = disp_load_q;
    assign busy_o       = busy_q;
    assign halted_o     = halted_q;
    assign step_count_o = step_count_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer with short debounce/run periods.
module tb_cpu_step_sequencer;

    logic        clk;
    logic        rst_n;
    logic        btn;
    logic        run_mode;
    logic        busy;
    logic        halted;
    logic [15:0] step_count;
    logic [2:0]  state;
    logic [4:0]  pc_q;

    int checks = 0;
    int errors = 0;

    // Pulse monitors (count the strobe seen during the previous cycle)
    int cyc = 0;
    int n_ir = 0, n_rf = 0, n_pc = 0, n_disp = 0;
    int ir_cyc[$];

    cpu_step_sequencer_if #(.PC_W(5)) ifc ();

    cpu_step_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .RUN_PERIOD(8),
        .PC_W(5),
        .LAST_PC(3)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .control_btn_i(btn),
        .run_mode_i   (run_mode),
        .dp           (ifc),
        .busy_o       (busy),
        .halted_o     (halted),
        .step_count_o (step_count),
        .state_o      (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model driven by pc_en
    always @(posedge clk) begin
        if (!rst_n) pc_q <= 5'd0;
        else if (ifc.pc_en) pc_q <= pc_q + 5'd1;
    end
    assign ifc.pc_address = pc_q;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ifc.ir_load) begin
            n_ir = n_ir + 1;
            ir_cyc.push_back(cyc);
        end
        if (ifc.rf_we) n_rf = n_rf + 1;
        if (ifc.pc_en) n_pc = n_pc + 1;
        if (ifc.disp_load) n_disp = n_disp + 1;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        btn      = 1'b0;
        run_mode = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_ir(input string tag, input int budget);
        int k;
        k = 0;
        while (ifc.ir_load !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, ifc.ir_load, 1);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, halted, 1);
    endtask

    initial begin
        int s_ir, s_rf, s_pc, s_disp, q0;
        rst_n              = 1'b0;
        btn                = 1'b0;
        run_mode           = 1'b0;
        ifc.instruction    = 32'h00A0_0093;
        ifc.dec_reg_write  = 1'b1;

        // 1. Reset values
        do_reset();
        check("rst_state", state, 0);
        check("rst_outs", {ifc.ir_load, ifc.rf_we, ifc.pc_en, ifc.disp_load, busy, halted}, 0);
        check("rst_count", step_count, 0);
        tick(2);
        check("idle_after_rst", state, 0);

        // 2. Bounce rejected, then a held press gives one step
        s_ir = n_ir;
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(12);
        check("bounce_no_fetch", n_ir - s_ir, 0);
        btn = 1'b1;
        wait_ir("press_fetch", 30);
        check("fetch_state", state, 1);
        check("fetch_busy", busy, 1);
        tick(1);
        check("exec_state", state, 2);
        check("exec_quiet", {ifc.ir_load, ifc.rf_we, ifc.pc_en, ifc.disp_load}, 0);
        tick(1);
        check("wb_state", state, 3);
        check("wb_strobes", {ifc.rf_we, ifc.disp_load, ifc.pc_en, ifc.ir_load}, 4'b1110);
        tick(1);
        check("step_idle", state, 0);
        check("step_count1", step_count, 1);
        check("step_pc1", pc_q, 1);
        check("step_not_busy", busy, 0);
        tick(20);
        btn = 1'b0;
        tick(20);
        check("one_fetch_only", n_ir - s_ir, 1);

        // 3. Run mode: one step every 8 cycles, halts after pc 3
        do_reset();
        s_ir = n_ir; s_rf = n_rf; s_pc = n_pc; s_disp = n_disp;
        q0 = ir_cyc.size();
        run_mode = 1'b1;
        wait_halt("run_halt", 200);
        check("run_count4", step_count, 4);
        check("run_pc3", pc_q, 3);
        check("run_pc_en3", n_pc - s_pc, 3);
        check("run_rf_we4", n_rf - s_rf, 4);
        check("run_disp4", n_disp - s_disp, 4);
        check("run_fetches4", ir_cyc.size() - q0, 4);
        if (ir_cyc.size() - q0 == 4) begin
            for (int i = 1; i < 4; i++)
                check("run_period", ir_cyc[q0 + i] - ir_cyc[q0 + i - 1], 8);
        end
        s_ir = n_ir;
        tick(50);
        check("halt_no_fetch", n_ir - s_ir, 0);
        check("halt_stays", {halted, busy, state}, {1'b1, 1'b0, 3'd4});

        // 4. Halt word in EXEC
        do_reset();
        ifc.instruction = 32'h0000_0073;
        s_rf = n_rf; s_pc = n_pc; s_disp = n_disp;
        btn = 1'b1;
        wait_ir("halt_fetch", 30);
        tick(1);
        check("halt_exec", state, 2);
        tick(1);
        check("halt_state", state, 4);
        check("halt_flag", halted, 1);
        check("halt_quiet", {ifc.rf_we, ifc.disp_load, ifc.pc_en, busy}, 0);
        check("halt_count", step_count, 0);
        btn = 1'b0;
        tick(20);
        s_ir = n_ir;
        btn = 1'b1;
        tick(20);
        btn = 1'b0;
        check("halt_ignores_btn", n_ir - s_ir, 0);
        check("halt_no_wb", {n_rf - s_rf, n_pc - s_pc, n_disp - s_disp}, 0);

        // 5. Reset during EXEC
        do_reset();
        ifc.instruction = 32'h0021_8233;
        s_rf = n_rf; s_pc = n_pc; s_disp = n_disp;
        btn = 1'b1;
        wait_ir("mid_fetch", 30);
        tick(1);
        check("mid_exec", state, 2);
        rst_n = 1'b0;
        btn   = 1'b0;
        tick(1);
        check("mid_rst_idle", state, 0);
        check("mid_rst_outs", {ifc.rf_we, ifc.disp_load, ifc.pc_en, busy}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("mid_no_wb", {n_rf - s_rf, n_pc - s_pc, n_disp - s_disp}, 0);
        check("mid_count0", step_count, 0);
        btn = 1'b1;
        wait_ir("fresh_fetch", 30);
        tick(3);
        check("fresh_idle", state, 0);
        check("fresh_count1", step_count, 1);
        check("fresh_pc1", pc_q, 1);
        btn = 1'b0;

        // 6. Button press debounced while a run-mode step is in flight
        do_reset();
        s_ir = n_ir;
        run_mode = 1'b1;
        tick(3);
        btn = 1'b1;
        wait_ir("busy_fetch", 30);
        run_mode = 1'b0;
        tick(30);
        check("busy_drop_fetch", n_ir - s_ir, 1);
        check("busy_drop_count", step_count, 1);
        check("busy_drop_idle", state, 0);
        btn = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
